// File: rtl/oled_pkg.sv
// Shared types and the SSD1331 power-up command list for the OLED command sequencer.
package oled_pkg;

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RST_WAIT,
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DELAY
  } oled_state_t;

  // Field order matches host writedata[9:0]: {delay, dc, byte}.
  typedef struct packed {
    logic       delay;
    logic       dc;
    logic [7:0] data;
  } oled_entry_t;

  localparam int INIT_LEN = 13;

  // Display off, remap/colour, start line, normal display, mux ratio, master config, display on.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
    8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hAF
  };

endpackage

// File: rtl/oled_cmd_fifo.sv
// Synchronous command FIFO with full/empty/count, simultaneous push/pop and a drop flag.
module oled_cmd_fifo
  import oled_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  oled_entry_t              push_data_i,
  input  logic                     pop_i,
  output oled_entry_t              head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  oled_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Sequences display reset, the ROM init list and host-queued bytes/delays into spimaster.
module oled_cmd_sequencer
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SPI_N      = 16,
  parameter int RST_HOLD   = 1000,
  parameter int RST_WAIT   = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [31:0] spi_writedata,
  output logic        spi_write,
  input  logic [31:0] spi_readdata,
  output logic        spi_reset
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(INIT_LEN);
  localparam int GUARD = 8 * SPI_N + 2;

  oled_state_t      state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [8:0]       wdata_q, wdata_d;
  logic             init_done_q, init_done_d;
  logic             ovf_q, ovf_d;

  oled_entry_t      head;
  logic             full, empty, drop, pop;
  logic [CW-1:0]    count;
  logic             busy;
  logic             spi_idle;
  logic             unused_bits;

  assign spi_idle    = spi_readdata[0];
  assign unused_bits = ^{writedata[31:10], spi_readdata[31:1]};

  oled_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (write),
    .push_data_i (oled_entry_t'(writedata[9:0])),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .drop_o      (drop)
  );

  // The power-up reset phases do not count as busy, so the status word reads 2 out of reset.
  assign busy = !(state_q inside {S_RST_HOLD, S_RST_WAIT, S_IDLE}) || !empty;

  assign readdata      = {22'b0, count, ovf_q, busy, init_done_q, empty, full};
  assign spi_writedata = {23'b0, wdata_q};
  assign spi_write     = (state_q == S_ISSUE);
  assign spi_reset     = (state_q == S_RST_HOLD);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    init_done_d = init_done_q;
    pop         = 1'b0;
    unique case (state_q)
      S_RST_HOLD: begin
        if (cnt_q == 16'(RST_HOLD - 1)) begin
          state_d = S_RST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == 16'(RST_WAIT - 1)) begin
          state_d = S_INIT;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_INIT: begin
        wdata_d = {1'b0, INIT_ROM[idx_q]};
        state_d = S_ISSUE;
      end
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.delay) begin
            cnt_d   = {head.data, 8'h00};
            state_d = S_DELAY;
          end else begin
            wdata_d = {head.dc, head.data};
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        // Guard first so spimaster has raised busy before its idle bit is trusted.
        if (cnt_q != 16'(GUARD - 1)) begin
          cnt_d = cnt_q + 16'd1;
        end else if (spi_idle) begin
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_INIT;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_RST_HOLD;
    endcase
  end

  // A fresh overflow in the read cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)      ovf_d = 1'b1;
    else if (read) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Directed self-checking bench for oled_cmd_sequencer with short reset phases and SPI_N=2.
module tb_oled_cmd_sequencer;

  localparam int SPI_N = 2;
  localparam int GAP   = 8 * SPI_N + 4;   // spi_write to spi_write with an always-idle SPI

  logic        clk;
  logic        resetn;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [31:0] readdata;
  logic [31:0] spi_writedata;
  logic        spi_write;
  logic [31:0] spi_readdata;
  logic        spi_reset;
  logic        spi_idle;

  int cmps = 0;
  int errs = 0;
  int cyc  = 0;
  int w0;

  logic [9:0] q_data [$];
  int         q_cyc  [$];

  logic [7:0] exp_rom [13] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
                               8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hAF};

  assign spi_readdata = {31'b0, spi_idle};

  oled_cmd_sequencer #(
    .FIFO_DEPTH (16),
    .SPI_N      (SPI_N),
    .RST_HOLD   (4),
    .RST_WAIT   (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .writedata     (writedata),
    .write         (write),
    .read          (read),
    .readdata      (readdata),
    .spi_writedata (spi_writedata),
    .spi_write     (spi_write),
    .spi_readdata  (spi_readdata),
    .spi_reset     (spi_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spi_write) begin
      q_data.push_back(spi_writedata[9:0]);
      q_cyc.push_back(cyc);
      $display("spi_write #%0d cyc=%0d data=%03h", q_data.size(), cyc, spi_writedata[9:0]);
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] e);
    writedata = {22'b0, e};
    write     = 1'b1;
    step();
    write     = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, q_data.size(), n);
  endtask

  task automatic wait_status(input int bitpos, input logic val, input int budget, input string tag);
    int k = 0;
    while (readdata[bitpos] !== val && k < budget) begin
      step();
      k++;
    end
    check(tag, readdata[bitpos], val);
  endtask

  initial begin
    resetn    = 1'b0;
    writedata = '0;
    write     = 1'b0;
    read      = 1'b0;
    spi_idle  = 1'b1;
    step(3);
    check("rst_readdata", readdata, 32'h2);
    check("rst_spi_reset", spi_reset, 1'b1);
    check("rst_spi_write", spi_write, 1'b0);
    check("rst_spi_wdata", spi_writedata, 32'h0);

    // Power-up: cycle 0 is the first cycle with resetn high.
    resetn = 1'b1;
    q_data.delete(); q_cyc.delete();
    check("pu_readdata", readdata, 32'h2);
    for (int i = 0; i < 4; i++) begin
      check("pu_hold_hi", spi_reset, 1'b1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("pu_wait_lo", spi_reset, 1'b0);
      step();
    end
    check("pu_no_write_c8", spi_write, 1'b0);
    step();
    check("pu_first_write_c9", spi_write, 1'b1);
    check("pu_first_byte", spi_writedata, 32'h0AE);
    wait_status(2, 1'b1, 1000, "pu_init_done_timeout");
    check("pu_init_count", q_data.size(), 13);
    for (int i = 0; i < 13 && i < q_data.size(); i++) begin
      check("pu_rom_byte", q_data[i], {2'b00, exp_rom[i]});
      if (i > 0) check("pu_rom_gap", q_cyc[i] - q_cyc[i-1], GAP);
    end
    check("pu_status_idle", readdata, 32'h6);

    // Single data byte, held through a stalled transfer.
    q_data.delete(); q_cyc.delete();
    push(10'h1A5);
    check("sb_busy_queued", readdata[3], 1'b1);
    check("sb_no_write_yet", spi_write, 1'b0);
    step();
    check("sb_write_pulse", spi_write, 1'b1);
    check("sb_wdata", spi_writedata, 32'h1A5);
    spi_idle = 1'b0;
    step(30);
    check("sb_wdata_held", spi_writedata, 32'h1A5);
    check("sb_single_pulse", spi_write, 1'b0);
    check("sb_busy_stalled", readdata[3], 1'b1);
    spi_idle = 1'b1;
    step();
    check("sb_busy_cleared", readdata, 32'h6);
    check("sb_count", q_data.size(), 1);
    check("sb_data", q_data[0], 10'h1A5);

    // Overflow with the SPI stalled: one entry in flight, then 17 pushes.
    q_data.delete(); q_cyc.delete();
    spi_idle = 1'b0;
    push(10'h111);
    step(3);
    for (int i = 0; i < 17; i++) begin
      writedata = 32'h020 + i;
      write     = 1'b1;
      step();
    end
    write = 1'b0;
    check("ov_status_full", readdata, 32'h21D);
    read = 1'b1;
    check("ov_visible_on_read", readdata[4], 1'b1);
    step();
    read = 1'b0;
    check("ov_cleared", readdata, 32'h20D);
    spi_idle = 1'b1;
    wait_q(17, 17 * (GAP + 5), "ov_drain_timeout");
    wait_status(3, 1'b0, 200, "ov_idle_timeout");
    check("ov_total", q_data.size(), 17);
    check("ov_first", q_data[0], 10'h111);
    for (int i = 0; i < 16 && i + 1 < q_data.size(); i++)
      check("ov_order", q_data[i+1], 10'h020 + 10'(i));

    // Push on the cycle the full FIFO pops.
    q_data.delete(); q_cyc.delete();
    spi_idle = 1'b0;
    push(10'h0C0);
    for (int i = 0; i < 16; i++) begin
      writedata = 32'h040 + i;
      write     = 1'b1;
      step();
    end
    write = 1'b0;
    step(25);
    check("fp_full_before", readdata, 32'h20D);
    spi_idle = 1'b1;
    step();
    writedata = 32'h0F0;
    write     = 1'b1;
    spi_idle  = 1'b0;
    step();
    write = 1'b0;
    check("fp_count_ovf", readdata, 32'h20D);
    spi_idle = 1'b1;
    wait_q(18, 18 * (GAP + 5), "fp_drain_timeout");
    wait_status(3, 1'b0, 200, "fp_idle_timeout");
    check("fp_first", q_data[0], 10'h0C0);
    for (int i = 0; i < 16; i++) check("fp_order", q_data[i+1], 10'h040 + 10'(i));
    check("fp_last", q_data[17], 10'h0F0);

    // Delay 5*256: pop at w+1, DELAY w+2..w+1282, IDLE w+1283, ISSUE w+1284.
    q_data.delete(); q_cyc.delete();
    w0 = cyc;
    push(10'h205);
    push(10'h0AF);
    step(10);
    check("dl_status_mid", readdata, 32'h2C);
    wait_q(1, 1500, "dl_timeout");
    check("dl_latency", q_cyc[0] - w0, 1284);
    check("dl_byte", q_data[0], 10'h0AF);
    step(GAP);

    // Reset while a transfer is stalled with 3 entries queued.
    spi_idle = 1'b0;
    push(10'h155);
    push(10'h061);
    push(10'h062);
    push(10'h063);
    step(5);
    check("mr_queued", readdata, 32'h6C);
    resetn = 1'b0;
    step();
    check("mr_readdata", readdata, 32'h2);
    check("mr_spi_reset", spi_reset, 1'b1);
    check("mr_spi_write", spi_write, 1'b0);
    check("mr_spi_wdata", spi_writedata, 32'h0);
    resetn   = 1'b1;
    spi_idle = 1'b1;
    q_data.delete(); q_cyc.delete();
    wait_status(2, 1'b1, 1000, "mr_init_timeout");
    check("mr_init_count", q_data.size(), 13);
    check("mr_init_first", q_data[0], 10'h0AE);
    check("mr_init_last", q_data[12], 10'h0AF);
    step(50);
    check("mr_flushed", q_data.size(), 13);
    check("mr_status", readdata, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/oled_cmd_sequencer.md
# oled_cmd_sequencer

- Command sequencer between the Avalon-MM host (Nios) and `spimaster`, which drives the SSD1331 OLED.
- After reset it pulses the display reset, then streams a fixed init command list from ROM.
- It then drains a host-filled command FIFO one byte at a time, holding each byte stable for the whole SPI transfer and inserting host-requested delays.
- Replaces direct software polling of the SPI master busy bit.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: command FIFO entries (power of 2).
- `SPI_N`, 16: `spimaster` clocks per bit; sets minimum transfer guard.
- `RST_HOLD`, 1000: cycles `spi_reset` held high after reset.
- `RST_WAIT`, 1000: cycles waited after releasing `spi_reset` before init.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `resetn` in 1: synchronous active-low reset.
- `writedata` in 32: host entry. [7:0] byte; [8] dc (1=data, 0=command); [9] delay flag.
- `write` in 1: host push strobe.
- `read` in 1: host status read strobe.
- `readdata` out 32: status.
  - [0] full; [1] empty; [2] init_done; [3] busy (not idle, or FIFO non-empty).
  - [4] overflow (sticky); [9:5] count; rest 0.
- `spi_writedata` out 32: to `spimaster.writedata`. [7:0] byte, [8] dc, rest 0.
- `spi_write` out 1: one-cycle start pulse to `spimaster.write`.
- `spi_readdata` in 32: from `spimaster.readdata`; bit0 = 1 means idle.
- `spi_reset` out 1: active-high reset to `spimaster`; holds display resetn low.

## Operation
- FSM states: RST_HOLD, RST_WAIT, INIT, IDLE, ISSUE, XFER, DELAY.
- **RST_HOLD**: `spi_reset`=1; 16-bit counter runs `RST_HOLD` cycles, then RST_WAIT.
- **RST_WAIT**: `spi_reset`=0; counter runs `RST_WAIT` cycles, then INIT with ROM index 0.
- **INIT**: loads ROM[idx] into `spi_writedata`, goes to ISSUE.
  - After XFER of entry `INIT_LEN-1`, sets init_done and goes to IDLE.
- **IDLE**: if FIFO non-empty, pops the head entry.
  - Delay entry: load counter with byte×256, go to DELAY.
  - Otherwise: load `spi_writedata`, go to ISSUE.
- **ISSUE**: `spi_write`=1 for exactly one cycle, then XFER.
- **XFER**:
  - Guard counter runs 8·`SPI_N`+2 cycles.
  - Then waits until `spi_readdata[0]`=1.
  - Then returns to INIT (next ROM entry) or IDLE.
  - `spi_writedata` is held unchanged from load until leaving XFER.
- **DELAY**: count down to 0, then IDLE. Delay byte 0 gives 1 cycle in DELAY.
- FIFO push rules:
  - `write` pushes `writedata[9:0]`, including during reset/init phases (drained after init).
  - Push when full with no simultaneous pop: dropped, overflow set.
  - Push and pop in the same cycle when full: accepted, count unchanged.
  - No bypass: a push to an empty FIFO is not poppable the same cycle.
- Overflow clears on the cycle after a `read` strobe, unless a new overflow occurs in that same cycle (set wins).
- Counters saturate at nothing: all loads are bounded by parameters; count width is $clog2(FIFO_DEPTH)+1.
- `resetn`=0 at any time: FSM returns to RST_HOLD, FIFO is flushed, init restarts. An in-flight SPI transfer is abandoned, because `spi_reset` resets `spimaster`.

## Timing
- Reset values:
  - `spi_reset`=1, `spi_write`=0, `spi_writedata`=0.
  - `readdata`=32'h2 (empty=1, all else 0); overflow=0, count=0.
- `readdata` is combinational from registered state; valid in the same cycle as `read`.
- Host write to empty FIFO in IDLE: pop at edge +1, `spi_write` high in cycle +2.
- Back-to-back bytes: next `spi_write` no earlier than 8·`SPI_N`+4 cycles after the previous one.
- Power-up: first `spi_write` at cycle `RST_HOLD`+`RST_WAIT`+1 after `resetn` rises.

## Structure
- Package `oled_pkg` holds:
  - `oled_state_t` enum;
  - `oled_entry_t` packed struct {delay, dc, byte};
  - `INIT_LEN` and `INIT_ROM` constant array (SSD1331 init: 0xAE display off … 0xAF display on, all dc=0).
- Sub-module `oled_cmd_fifo`: synchronous FIFO of `oled_entry_t` with full/empty/count and simultaneous push/pop.
- FSM and counters in the top.

## Test plan
- **Power-up**: release `resetn` with `RST_HOLD`=`RST_WAIT`=4 → `spi_reset` high 4 cycles, low 4 cycles, then `INIT_LEN` pulses on `spi_write` carrying ROM bytes in order; init_done=1 afterwards.
- **Single data byte**: after init, write 0x1A5 → `spi_writedata`=0x1A5 held through XFER; one `spi_write` pulse 2 cycles later; readdata[3] returns to 0 when `spi_readdata[0]`=1.
- **Overflow**: with a stalled SPI model (idle=0), push 17 entries → full=1, count=16, overflow=1; one `read` clears overflow; all 16 entries are later issued in order.
- **Delay**: push 0x205 then 0x0AF → 1280 cycles between the end of DELAY entry and ISSUE of 0xAF.
- **Reset mid-operation**: assert `resetn`=0 during XFER with 3 queued entries → next cycle readdata=32'h2, `spi_reset`=1, `spi_write`=0; init sequence replays.
- **Full push+pop**: full FIFO with push in the pop cycle → count stays 16, overflow stays 0.
